// File: rtl/ram8.sv
// rtl/ram8.sv - eight-word register memory with demux-tree write steering and combinational read
// Leaves of the three-level demux tree are the per-word load enables; at most one is high.

module demux (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);
  assign a = in & ~sel;
  assign b = in & sel;
endmodule

module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);
  logic [1:0]       lvl1;
  logic [3:0]       lvl2;
  logic [7:0]       ld;
  logic [WIDTH-1:0] word [8];

  demux u_root (.in(load), .sel(address[2]), .a(lvl1[0]), .b(lvl1[1]));

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_lvl2
      demux u_mid (.in(lvl1[g]), .sel(address[1]), .a(lvl2[2*g]), .b(lvl2[2*g+1]));
    end
    for (g = 0; g < 4; g++) begin : g_leaf
      demux u_leaf (.in(lvl2[g]), .sel(address[0]), .a(ld[2*g]), .b(ld[2*g+1]));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) word[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (ld[i]) word[i] <= in;
    end
  end

  // Read path has no write-through: it only ever sees stored words.
  assign out = word[address];
endmodule

// File: tb/tb_ram8.sv
// tb/tb_ram8.sv - scoreboard bench for ram8
// Expected words come from a reference array updated when writes are driven.

module tb_ram8;
  logic        clk = 0;
  logic        reset = 1;
  logic [15:0] in = '0;
  logic        load = 0;
  logic [2:0]  address = '0;
  logic [15:0] out;

  logic [15:0] mem [8];
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;
  int checks = 0;
  int failures = 0;

  ram8 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .address(address), .out(out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; in = d; load = 1;
    @(posedge clk);
    mem[a] = d;
    #1 load = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    reset = 1; load = 1; in = 16'hFFFF;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = i[2:0]; #1;
      exp_q.push_back(16'h0);
      exp_v = exp_q.pop_front(); checks++;
      if (out !== exp_v) begin
        failures++; $display("FAIL reset_held addr=%0d got=%h exp=%h", i, out, exp_v);
      end
    end
    load = 0; in = '0;
    @(negedge clk); reset = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = i[2:0]; #1;
      exp_q.push_back(mem[i]);
      exp_v = exp_q.pop_front(); checks++;
      if (out !== exp_v) begin
        failures++; $display("FAIL reset_state addr=%0d got=%h exp=%h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_write_read_all();
    for (int i = 0; i < 8; i++) do_write(i[2:0], 16'h1111 * 16'(i + 1));
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = i[2:0]; #1;
      exp_q.push_back(16'h1111 * 16'(i + 1));
      exp_v = exp_q.pop_front(); checks++;
      if (out !== exp_v) begin
        failures++; $display("FAIL write_read_all addr=%0d got=%h exp=%h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_load_gating();
    do_write(3'd3, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load = 0; in = 16'h0000; address = i[2:0];
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = i[2:0]; #1;
      exp_q.push_back(mem[i]);
      exp_v = exp_q.pop_front(); checks++;
      if (out !== exp_v) begin
        failures++; $display("FAIL load_gating addr=%0d got=%h exp=%h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_read_during_write();
    do_write(3'd5, 16'h00AA);
    @(negedge clk);
    address = 3'd5; in = 16'h0055; load = 1; #1;
    exp_q.push_back(16'h00AA);
    exp_v = exp_q.pop_front(); checks++;
    if (out !== exp_v) begin
      failures++; $display("FAIL rdw_before_edge got=%h exp=%h", out, exp_v);
    end
    @(posedge clk); mem[5] = 16'h0055; #1;
    load = 0;
    exp_q.push_back(16'h0055);
    exp_v = exp_q.pop_front(); checks++;
    if (out !== exp_v) begin
      failures++; $display("FAIL rdw_after_edge got=%h exp=%h", out, exp_v);
    end
    do_write(3'd6, 16'hC3C3);
    @(negedge clk);
    for (int i = 5; i < 7; i++) begin
      address = i[2:0]; #1;
      exp_q.push_back(mem[i]);
      exp_v = exp_q.pop_front(); checks++;
      if (out !== exp_v) begin
        failures++; $display("FAIL rdw_other_addr addr=%0d got=%h exp=%h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) do_write(i[2:0], 16'hFFFF);
    @(negedge clk);
    address = 3'd2; in = 16'hFFFF; load = 1;
    #2 reset = 1;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    #1;
    exp_q.push_back(16'h0);
    exp_v = exp_q.pop_front(); checks++;
    if (out !== exp_v) begin
      failures++; $display("FAIL async_reset_immediate got=%h exp=%h", out, exp_v);
    end
    #1 reset = 0; load = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = i[2:0]; #1;
      exp_q.push_back(mem[i]);
      exp_v = exp_q.pop_front(); checks++;
      if (out !== exp_v) begin
        failures++; $display("FAIL async_reset_cleared addr=%0d got=%h exp=%h", i, out, exp_v);
      end
    end
    do_write(3'd2, 16'h1234);
    @(negedge clk);
    address = 3'd2; #1;
    exp_q.push_back(16'h1234);
    exp_v = exp_q.pop_front(); checks++;
    if (out !== exp_v) begin
      failures++; $display("FAIL post_reset_write got=%h exp=%h", out, exp_v);
    end
  endtask

  task automatic test_boundaries();
    for (int i = 1; i < 7; i++) do_write(i[2:0], 16'hA500 + 16'(i));
    do_write(3'd7, 16'h8000);
    do_write(3'd0, 16'h0001);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = i[2:0]; #1;
      exp_q.push_back(mem[i]);
      exp_v = exp_q.pop_front(); checks++;
      if (out !== exp_v) begin
        failures++; $display("FAIL boundaries addr=%0d got=%h exp=%h", i, out, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read_all();
    test_load_gating();
    test_read_during_write();
    test_async_reset();
    test_boundaries();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
